// File: rtl/pmm_dispatch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pmm_dispatch_arbiter
// Purpose  : Round-robin dispatch of two host requesters onto four pattern-
//            matching engine lanes. Each lane runs a valid/ready four-phase
//            handshake with a per-phase timeout. Engine pattern-accept events
//            and handshake timeouts are held in sticky, write-1-clear flags.
// Revision : 1.0 - initial release
// ============================================================================
module pmm_dispatch_arbiter #(
  parameter int DATA_W  = 64,
  parameter int CTRL_W  = 16,
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  input  logic [3:0]            req_sel,
  input  logic [2*DATA_W-1:0]   req_data,
  input  logic [2*CTRL_W-1:0]   req_control,
  output logic [1:0]            req_ready,
  output logic [4*DATA_W-1:0]   pmm_data,
  output logic [4*CTRL_W-1:0]   pmm_control,
  output logic [3:0]            pmm_data_valid,
  input  logic [3:0]            pmm_ready_status,
  input  logic [3:0]            pmm_accepted_status,
  output logic [3:0]            lane_busy,
  output logic [3:0]            hit_flags,
  input  logic [3:0]            hit_clear,
  output logic [3:0]            timeout_err,
  input  logic [3:0]            err_clear
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_RELEASE = 2'd2
  } lane_state_t;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  logic [1:0] sel0;
  logic [1:0] sel1;
  logic [3:0] lane_idle;
  logic [1:0] elig;
  logic [1:0] grant;
  logic       rr_ptr;
  logic [3:0] err_set;
  logic [3:0] acc_q;

  assign sel0 = req_sel[1:0];
  assign sel1 = req_sel[3:2];

  // A requester competes only when its target lane can take a new word.
  always_comb begin
    elig    = 2'b00;
    elig[0] = req_valid[0] & lane_idle[sel0];
    elig[1] = req_valid[1] & lane_idle[sel1];
  end

  // Single grant per cycle; rr_ptr only matters when both requesters compete,
  // regardless of whether they target the same lane.
  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      grant = rr_ptr ? 2'b10 : 2'b01;
    end
  end

  assign req_ready = grant;

  // After a grant the pointer favours the requester that lost (or idled).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (grant != 2'b00) begin
      rr_ptr <= grant[0];
    end
  end

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_lane
      lane_state_t       state_q;
      lane_state_t       state_d;
      logic [TO_W-1:0]   cnt_q;
      logic [TO_W-1:0]   cnt_d;
      logic              to_hit;
      logic              load;
      logic [DATA_W-1:0] load_data;
      logic [CTRL_W-1:0] load_ctrl;
      logic              valid_q;
      logic [DATA_W-1:0] data_q;
      logic [CTRL_W-1:0] ctrl_q;

      // Steer the granted requester's word to this lane (at most one grant).
      always_comb begin
        load      = 1'b0;
        load_data = req_data[0 +: DATA_W];
        load_ctrl = req_control[0 +: CTRL_W];
        if (grant[0] && (sel0 == 2'(i))) begin
          load = 1'b1;
        end else if (grant[1] && (sel1 == 2'(i))) begin
          load      = 1'b1;
          load_data = req_data[DATA_W +: DATA_W];
          load_ctrl = req_control[CTRL_W +: CTRL_W];
        end
      end

      // Handshake sequencing with a per-phase cycle budget.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        to_hit  = 1'b0;
        case (state_q)
          ST_IDLE: begin
            cnt_d = '0;
            if (load) begin
              state_d = ST_DRIVE;
            end
          end
          ST_DRIVE: begin
            if (pmm_ready_status[i]) begin
              state_d = ST_RELEASE;
              cnt_d   = '0;
            end else if (cnt_q == TO_MAX) begin
              to_hit  = 1'b1;
              state_d = ST_RELEASE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          ST_RELEASE: begin
            if (!pmm_ready_status[i]) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else if (cnt_q == TO_MAX) begin
              to_hit  = 1'b1;
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end

      // Lane registers; data/control persist until the next capture.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          valid_q <= 1'b0;
          data_q  <= '0;
          ctrl_q  <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          valid_q <= (state_d == ST_DRIVE);
          if (load && (state_q == ST_IDLE)) begin
            data_q <= load_data;
            ctrl_q <= load_ctrl;
          end
        end
      end

      assign lane_idle[i]                   = (state_q == ST_IDLE);
      assign lane_busy[i]                   = (state_q != ST_IDLE);
      assign pmm_data_valid[i]              = valid_q;
      assign pmm_data[DATA_W*i +: DATA_W]   = data_q;
      assign pmm_control[CTRL_W*i +: CTRL_W] = ctrl_q;
      assign err_set[i]                     = to_hit;
    end
  endgenerate

  // Sticky event flags; a new event in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= 4'b0000;
      hit_flags   <= 4'b0000;
      timeout_err <= 4'b0000;
    end else begin
      acc_q       <= pmm_accepted_status;
      hit_flags   <= (hit_flags & ~hit_clear) | (pmm_accepted_status & ~acc_q);
      timeout_err <= (timeout_err & ~err_clear) | err_set;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pmm_dispatch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmm_dispatch_arbiter
// Purpose  : Self-checking bench for pmm_dispatch_arbiter: cycle vector table
//            plus directed sequences for contention, timeout and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmm_dispatch_arbiter;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [1:0]          req_valid;
  logic [3:0]          req_sel;
  logic [2*DATA_W-1:0] req_data;
  logic [2*CTRL_W-1:0] req_control;
  logic [1:0]          req_ready;
  logic [4*DATA_W-1:0] pmm_data;
  logic [4*CTRL_W-1:0] pmm_control;
  logic [3:0]          pmm_data_valid;
  logic [3:0]          pmm_ready_status;
  logic [3:0]          pmm_accepted_status;
  logic [3:0]          lane_busy;
  logic [3:0]          hit_flags;
  logic [3:0]          hit_clear;
  logic [3:0]          timeout_err;
  logic [3:0]          err_clear;

  int checks = 0;
  int errors = 0;

  pmm_dispatch_arbiter #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .TIMEOUT(8),
    .TO_W   (4)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid          (req_valid),
    .req_sel            (req_sel),
    .req_data           (req_data),
    .req_control        (req_control),
    .req_ready          (req_ready),
    .pmm_data           (pmm_data),
    .pmm_control        (pmm_control),
    .pmm_data_valid     (pmm_data_valid),
    .pmm_ready_status   (pmm_ready_status),
    .pmm_accepted_status(pmm_accepted_status),
    .lane_busy          (lane_busy),
    .hit_flags          (hit_flags),
    .hit_clear          (hit_clear),
    .timeout_err        (timeout_err),
    .err_clear          (err_clear)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] rv;
    logic [3:0] sel;
    logic [3:0] rdy;
    logic [3:0] acc;
    logic [3:0] hclr;
    logic [1:0] e_rr;
    logic [3:0] e_v;
    logic [3:0] e_busy;
    logic [3:0] e_hit;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic [1:0] rv, input logic [3:0] sel, input logic [3:0] rdy,
                     input logic [3:0] acc, input logic [3:0] hclr, input logic [1:0] e_rr,
                     input logic [3:0] e_v, input logic [3:0] e_busy, input logic [3:0] e_hit);
    vec_t v;
    v.rv = rv; v.sel = sel; v.rdy = rdy; v.acc = acc; v.hclr = hclr;
    v.e_rr = e_rr; v.e_v = e_v; v.e_busy = e_busy; v.e_hit = e_hit;
    vq.push_back(v);
  endtask

  function automatic logic [63:0] word_of(input int code);
    return 64'hC0DE_0000_0000_0000 | 64'(code);
  endfunction

  localparam logic [63:0] D0 = 64'hDEAD_BEEF_0123_4567;
  localparam logic [15:0] C0 = 16'h00A5;
  localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;
  localparam logic [15:0] C1 = 16'h5A5A;

  initial begin
    int idx[2];
    int exp_q[$];
    int exp_win;
    int grants;
    int gi;
    int code;
    int vcount;
    logic prev_v;
    logic dropped;

    rst_n = 1'b0;
    req_valid = '0; req_sel = '0; req_data = '0; req_control = '0;
    pmm_ready_status = '0; pmm_accepted_status = '0; hit_clear = '0; err_clear = '0;

    //        rv     sel      rdy      acc      hclr     rr     valid    busy     hit
    // basic handshake on lane 2
    add(2'b01, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'b01, 4'b0000, 4'b0000, 4'b0000);
    add(2'b00, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0100, 4'b0100, 4'b0000);
    add(2'b01, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0100, 4'b0100, 4'b0000);
    add(2'b00, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 2'b00, 4'b0100, 4'b0100, 4'b0000);
    add(2'b00, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 2'b00, 4'b0000, 4'b0100, 4'b0000);
    add(2'b00, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 2'b00, 4'b0000, 4'b0100, 4'b0000);
    add(2'b00, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 4'b0100, 4'b0000);
    // req0 -> lane 0, req1 -> lane 3 together; rr_ptr is 1 so req1 first
    add(2'b11, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 2'b10, 4'b0000, 4'b0000, 4'b0000);
    add(2'b01, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 2'b01, 4'b1000, 4'b1000, 4'b0000);
    add(2'b00, 4'b1100, 4'b1001, 4'b0000, 4'b0000, 2'b00, 4'b1001, 4'b1001, 4'b0000);
    add(2'b00, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 4'b1001, 4'b0000);
    // accept events on lane 3
    add(2'b00, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b0000);
    add(2'b00, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b1000);
    add(2'b00, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b1000);
    add(2'b00, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b1000);
    add(2'b00, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b1000);
    add(2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b1000);
    add(2'b00, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 2'b00, 4'b0000, 4'b0000, 4'b1000);
    add(2'b00, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b1000);
    add(2'b00, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 2'b00, 4'b0000, 4'b0000, 4'b1000);
    add(2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b0000);

    // reset state
    @(negedge clk);
    @(negedge clk);
    #2;
    check("rst_valid", 64'(pmm_data_valid), 64'h0);
    check("rst_busy", 64'(lane_busy), 64'h0);
    check("rst_hit", 64'(hit_flags), 64'h0);
    check("rst_err", 64'(timeout_err), 64'h0);
    check("rst_data", 64'(|pmm_data), 64'h0);
    check("rst_ctrl", 64'(|pmm_control), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    req_data    = {D1, D0};
    req_control = {C1, C0};
    foreach (vq[k]) begin
      @(negedge clk);
      req_valid           = vq[k].rv;
      req_sel             = vq[k].sel;
      pmm_ready_status    = vq[k].rdy;
      pmm_accepted_status = vq[k].acc;
      hit_clear           = vq[k].hclr;
      #2;
      check($sformatf("v%0d_ready", k), 64'(req_ready), 64'(vq[k].e_rr));
      check($sformatf("v%0d_valid", k), 64'(pmm_data_valid), 64'(vq[k].e_v));
      check($sformatf("v%0d_busy", k), 64'(lane_busy), 64'(vq[k].e_busy));
      check($sformatf("v%0d_hit", k), 64'(hit_flags), 64'(vq[k].e_hit));
      check($sformatf("v%0d_err", k), 64'(timeout_err), 64'h0);
    end
    check("lane2_data", pmm_data[2*DATA_W +: DATA_W], D0);
    check("lane2_ctrl", 64'(pmm_control[2*CTRL_W +: CTRL_W]), 64'(C0));
    check("lane0_data", pmm_data[0 +: DATA_W], D0);
    check("lane3_data", pmm_data[3*DATA_W +: DATA_W], D1);
    check("lane3_ctrl", 64'(pmm_control[3*CTRL_W +: CTRL_W]), 64'(C1));
    check("lane1_untouched", pmm_data[1*DATA_W +: DATA_W], 64'h0);

    // same-lane contention on lane 1; engine mirrors valid half a cycle later
    idx[0] = 0; idx[1] = 0;
    exp_win = 1;
    grants = 0;
    prev_v = 1'b0;
    for (int cyc = 0; cyc < 80 && !(grants >= 6 && exp_q.size() == 0); cyc++) begin
      @(negedge clk);
      pmm_ready_status = {2'b00, pmm_data_valid[1], 1'b0};
      req_valid   = (grants < 6) ? 2'b11 : 2'b00;
      req_sel     = 4'b0101;
      req_data    = {word_of(256 + idx[1]), word_of(idx[0])};
      req_control = {16'(256 + idx[1]), 16'(idx[0])};
      #2;
      if (pmm_data_valid[1] && !prev_v) begin
        if (exp_q.size() == 0) begin
          check("cont_extra_word", 64'h1, 64'h0 | 64'(exp_q.size()));
        end else begin
          code = exp_q.pop_front();
          check("cont_data", pmm_data[DATA_W +: DATA_W], word_of(code));
          check("cont_ctrl", 64'(pmm_control[CTRL_W +: CTRL_W]), 64'(code));
        end
      end
      prev_v = pmm_data_valid[1];
      if (req_ready != 2'b00) begin
        check("cont_grant", 64'(req_ready), (exp_win == 1) ? 64'h2 : 64'h1);
        gi = req_ready[1] ? 1 : 0;
        exp_q.push_back(gi * 256 + idx[gi]);
        idx[gi]++;
        grants++;
        exp_win ^= 1;
      end
    end
    check("cont_grants", 64'(grants), 64'd6);
    check("cont_drained", 64'(exp_q.size()), 64'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      pmm_ready_status = {2'b00, pmm_data_valid[1], 1'b0};
      req_valid = 2'b00;
    end
    @(negedge clk);
    pmm_ready_status = 4'b0000;
    #2;
    check("cont_idle", 64'(lane_busy), 64'h0);

    // timeout on lane 0: engine never acknowledges (TIMEOUT = 8)
    @(negedge clk);
    req_valid = 2'b01;
    req_sel   = 4'b0000;
    #2;
    check("to_grant", 64'(req_ready), 64'h1);
    vcount  = 0;
    dropped = 1'b0;
    for (int c = 0; c < 20 && !dropped; c++) begin
      @(negedge clk);
      req_valid = 2'b00;
      #2;
      if (pmm_data_valid[0]) vcount++;
      else dropped = 1'b1;
    end
    check("to_valid_cycles", 64'(vcount), 64'd9);
    check("to_err_set", 64'(timeout_err), 64'h1);
    @(negedge clk);
    #2;
    check("to_idle", 64'(lane_busy), 64'h0);
    check("to_err_hold", 64'(timeout_err), 64'h1);
    @(negedge clk);
    err_clear = 4'b0001;
    #2;
    check("to_err_before_clr", 64'(timeout_err), 64'h1);
    @(negedge clk);
    err_clear = 4'b0000;
    #2;
    check("to_err_cleared", 64'(timeout_err), 64'h0);

    // asynchronous reset while lane 2 drives
    @(negedge clk);
    req_valid           = 2'b01;
    req_sel             = 4'b0010;
    req_data            = {D1, D0};
    req_control         = {C1, C0};
    pmm_accepted_status = 4'b0001;
    #2;
    check("rm_grant", 64'(req_ready), 64'h1);
    @(negedge clk);
    req_valid = 2'b00;
    #2;
    check("rm_valid_pre", 64'(pmm_data_valid), 64'h4);
    check("rm_hit_pre", 64'(hit_flags), 64'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rm_valid", 64'(pmm_data_valid), 64'h0);
    check("rm_busy", 64'(lane_busy), 64'h0);
    check("rm_hit", 64'(hit_flags), 64'h0);
    check("rm_err", 64'(timeout_err), 64'h0);
    check("rm_data", pmm_data[2*DATA_W +: DATA_W], 64'h0);
    @(negedge clk);
    pmm_accepted_status = 4'b0000;
    rst_n     = 1'b1;
    req_valid = 2'b11;
    req_sel   = 4'b1100;
    #2;
    check("rm_first_grant", 64'(req_ready), 64'h1);
    @(negedge clk);
    req_valid = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop so a stalled sequence can never hang the run.
  initial begin
    #20000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
